// File: rtl/spi_shadow_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_shadow_rx
// Description : SPI target receive path. Shifts MOSI in MSB-first while cs_n
//               is low, using the SPI serial clock as the block clock, and
//               publishes each completed DATA_WIDTH-bit word on a registered
//               shadow register.
// Ports       : clock      - SPI serial clock, data sampled on rising edge
//               reset_n    - asynchronous active-low reset
//               cs_n       - chip select, active low, synchronous to clock
//               mosi       - serial data in, MSB first
//               shadow_reg - last complete received word (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shadow_rx #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] SHADOW_INIT = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic [DATA_WIDTH-1:0] shadow_reg
);

  localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] w_word;

  // Word including the bit being sampled on this edge; this is what gets
  // published on the frame-complete edge, so there is no extra latency.
  assign w_word = {shift_q[DATA_WIDTH-2:0], mosi};

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    if (cs_n) begin
      // Deselected: any partial frame is dropped by restarting the count.
      bit_cnt_d = '0;
    end else begin
      shift_d = w_word;
      if (bit_cnt_q == LAST_BIT) begin
        // Explicit wrap keeps non-power-of-two widths correct.
        bit_cnt_d = '0;
        shadow_d  = w_word;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      shadow_q  <= SHADOW_INIT;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
    end
  end

  assign shadow_reg = shadow_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_shadow_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_shadow_rx
// Description : Directed self-checking bench for spi_shadow_rx. The host
//               drives cs_n/mosi on falling edges; results are sampled 1ns
//               after the rising edge that completes each step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shadow_rx;

  localparam int DATA_WIDTH = 16;

  logic                  clock;
  logic                  reset_n;
  logic                  cs_n;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] shadow_reg;

  int n_checks;
  int n_errors;

  spi_shadow_rx #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHADOW_INIT (16'h0000)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .shadow_reg (shadow_reg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bit: driven on the falling edge, sampled on the next rising edge.
  task automatic send_bit(input logic b);
    @(negedge clock);
    cs_n = 1'b0;
    mosi = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  // Deselect for n cycles with mosi toggling so it is shown to be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cs_n = 1'b1;
      mosi = ~mosi;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_shadow", 32'(shadow_reg), 32'h0000);
    check_eq("reset_bitcnt", 32'(dut.bit_cnt_q), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic frame: word must not appear before the 16th edge
    w = 16'hDEAD;
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    check_eq("basic_15bits", 32'(shadow_reg), 32'h0000);
    send_bit(w[0]);
    check_eq("basic_16bits", 32'(shadow_reg), 32'hDEAD);
    idle(3);
    check_eq("basic_idle_hold", 32'(shadow_reg), 32'hDEAD);

    // Short frame discarded, then full frame proves counter was cleared
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    idle(2);
    check_eq("short_hold", 32'(shadow_reg), 32'hDEAD);
    check_eq("short_bitcnt", 32'(dut.bit_cnt_q), 32'h0);
    send_word(16'h1234);
    check_eq("after_short", 32'(shadow_reg), 32'h1234);
    idle(1);

    // Back-to-back: cs_n held low for 32 edges
    send_word(16'hBEEF);
    check_eq("b2b_first", 32'(shadow_reg), 32'hBEEF);
    w = 16'hCAFE;
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    check_eq("b2b_mid_hold", 32'(shadow_reg), 32'hBEEF);
    send_bit(w[0]);
    check_eq("b2b_second", 32'(shadow_reg), 32'hCAFE);
    idle(1);

    // Reset mid-frame after 5 bits
    w = 16'h5A5A;
    for (int i = 15; i >= 11; i--) send_bit(w[i]);
    @(negedge clock);
    reset_n = 1'b0;
    cs_n    = 1'b1;
    #1;
    check_eq("midreset_shadow", 32'(shadow_reg), 32'h0000);
    check_eq("midreset_bitcnt", 32'(dut.bit_cnt_q), 32'h0);
    check_eq("midreset_shift", 32'(dut.shift_q), 32'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    send_word(16'hA5A5);
    check_eq("after_reset", 32'(shadow_reg), 32'hA5A5);
    idle(1);

    // Bit patterns exercising MSB/LSB ordering
    send_word(16'h0000);
    check_eq("pat_0000", 32'(shadow_reg), 32'h0000);
    idle(1);
    send_word(16'hFFFF);
    check_eq("pat_ffff", 32'(shadow_reg), 32'hFFFF);
    idle(1);
    send_word(16'h8001);
    check_eq("pat_8001", 32'(shadow_reg), 32'h8001);
    idle(1);
    send_word(16'h0001);
    check_eq("pat_0001", 32'(shadow_reg), 32'h0001);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
